// File: rtl/keypad_scanner_if.sv
// Key output bundle of the keypad scanner: accepted key events, digit register
// and the data clear request coming back from the consumer.
interface keypad_scanner_if;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] data;

  modport master (
    input  clear,
    output key_valid,
    output key_code,
    output key_down,
    output data
  );

  modport slave (
    output clear,
    input  key_valid,
    input  key_code,
    input  key_down,
    input  data
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex matrix keypad scanner: column scan, per-frame hit classification,
// press/release debounce and a 32-bit shift register of accepted hex digits.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       col,
  input  logic [3:0]       row,
  keypad_scanner_if.master kbus
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  function automatic logic [2:0] hit_count(input logic [3:0] h);
    return {2'b00, h[0]} + {2'b00, h[1]} + {2'b00, h[2]} + {2'b00, h[3]};
  endfunction

  function automatic logic [1:0] sat_hits(input logic [1:0] acc, input logic [2:0] add);
    logic [2:0] sum;
    sum = {1'b0, acc} + add;
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

  function automatic logic [1:0] first_hit(input logic [3:0] h);
    if (h[0])      return 2'd0;
    else if (h[1]) return 2'd1;
    else if (h[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: return 4'h1;  4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;  4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;  4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;  4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;  4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;  4'b10_11: return 4'hC;
      4'b11_00: return 4'h0;  4'b11_01: return 4'hF;
      4'b11_10: return 4'hE;  default:  return 4'hD;
    endcase
  endfunction

  logic [3:0]        row_p0, row_p1;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        c;
  logic [1:0]        frm_hits;
  logic [3:0]        frm_code;
  state_t            state, state_nxt;
  logic [3:0]        cand, cand_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept, release_key;
  logic [3:0]        acc_code;

  // stage p0/p1: two-flop row synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  logic       sample, frame_end;
  logic [3:0] cur_hits;
  logic [2:0] cur_cnt;
  logic [1:0] tot_hits;
  logic [3:0] res_code;

  assign col       = ~(4'b0001 << c);
  assign sample    = (slot == SLOT_LAST);
  assign frame_end = sample && (c == 2'd3);
  assign cur_hits  = ~row_p1;
  assign cur_cnt   = hit_count(cur_hits);
  assign tot_hits  = sat_hits(frm_hits, cur_cnt);
  assign res_code  = (cur_cnt == 3'd1) ? key_map(first_hit(cur_hits), c) : frm_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      c        <= 2'd0;
      frm_hits <= 2'd0;
      frm_code <= 4'h0;
    end else begin
      slot <= sample ? '0 : slot + SLOT_W'(1);
      if (sample) begin
        c <= c + 2'd1;
        // hit tally restarts with each frame
        frm_hits <= frame_end ? 2'd0 : tot_hits;
        frm_code <= frame_end ? 4'h0 : res_code;
      end
    end
  end

  logic is_none, is_key;
  assign is_none = (tot_hits == 2'd0);
  assign is_key  = (tot_hits == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= 4'h0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    if (frame_end) begin
      case (state)
        IDLE: if (is_key) begin
          state_nxt = (DEBOUNCE == 1) ? HELD : PRESS_WAIT;
          cand_nxt  = res_code;
          cnt_nxt   = CNT_W'(1);
        end
        PRESS_WAIT: begin
          if (is_key && res_code == cand) begin
            if (cnt == DEB_LAST) state_nxt = HELD;
            else                 cnt_nxt   = cnt + CNT_W'(1);
          end else if (is_key) begin
            cand_nxt = res_code;
            cnt_nxt  = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: if (is_none) begin
          state_nxt = (DEBOUNCE == 1) ? IDLE : RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
        default: begin
          if (!is_none)             state_nxt = HELD;
          else if (cnt == DEB_LAST) state_nxt = IDLE;
          else                      cnt_nxt   = cnt + CNT_W'(1);
        end
      endcase
    end
  end

  always_comb begin
    accept      = 1'b0;
    release_key = 1'b0;
    acc_code    = cand;
    if (frame_end) begin
      case (state)
        IDLE: begin
          accept   = is_key && (DEBOUNCE == 1);
          acc_code = res_code;
        end
        PRESS_WAIT:   accept      = is_key && (res_code == cand) && (cnt == DEB_LAST);
        HELD:         release_key = is_none && (DEBOUNCE == 1);
        default:      release_key = is_none && (cnt == DEB_LAST);
      endcase
    end
  end

  // stage p2: registered key outputs and digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbus.key_valid <= 1'b0;
      kbus.key_code  <= 4'h0;
      kbus.key_down  <= 1'b0;
      kbus.data      <= 32'h0;
    end else begin
      kbus.key_valid <= accept;
      if (accept) begin
        kbus.key_code <= acc_code;
        kbus.key_down <= 1'b1;
        kbus.data     <= kbus.clear ? {28'h0, acc_code} : {kbus.data[27:0], acc_code};
      end else begin
        if (release_key) kbus.key_down <= 1'b0;
        if (kbus.clear)  kbus.data     <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames)
// and a combinational keypad model driven by a set of pressed matrix positions.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [15:0] pressed;
  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int base;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner_if kbus();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .col   (col),
    .row   (row),
    .kbus  (kbus)
  );

  always #5 clk = ~clk;

  // matrix position p = row*4 + column; a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int p = 0; p < 16; p++)
      if (pressed[p] && !col[p % 4]) row[p / 4] = 1'b0;
  end

  always @(negedge clk) if (rst_n && kbus.key_valid) nvalid++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (kmap[i] == k) return i;
    return 0;
  endfunction

  task automatic frames(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    pressed[pos_of(k)] = 1'b1;
  endtask

  task automatic tap(input logic [3:0] k);
    press(k);
    frames(4);
    pressed = '0;
    frames(4);
  endtask

  // leaves the bench at the negedge of the first cycle of a frame (column 0, slot 0)
  task automatic sync_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b0111) found = 1'b1;
    end
    chk("sync_c3", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1110) found = 1'b1;
    end
    chk("sync_c0", 32'(found), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    pressed = '0;
    kbus.clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col), 32'h0000000E);
    chk("rst_valid", 32'(kbus.key_valid), 32'd0);
    chk("rst_code", 32'(kbus.key_code), 32'd0);
    chk("rst_down", 32'(kbus.key_down), 32'd0);
    chk("rst_data", kbus.data, 32'd0);
    rst_n = 1'b1;

    sync_frame();
    chk("scan_c0", 32'(col), 32'h0000000E);
    repeat (4) @(negedge clk);
    chk("scan_c1", 32'(col), 32'h0000000D);
    repeat (4) @(negedge clk);
    chk("scan_c2", 32'(col), 32'h0000000B);
    repeat (4) @(negedge clk);
    chk("scan_c3", 32'(col), 32'h00000007);
    frames(10);
    chk("idle_pulses", 32'(nvalid), 32'd0);
    chk("idle_data", kbus.data, 32'd0);

    press(4'h6);
    frames(5);
    chk("k6_pulses", 32'(nvalid), 32'd1);
    chk("k6_code", 32'(kbus.key_code), 32'h6);
    chk("k6_data", kbus.data, 32'h00000006);
    chk("k6_down", 32'(kbus.key_down), 32'd1);
    pressed = '0;
    frames(1);
    chk("k6_down_hold", 32'(kbus.key_down), 32'd1);
    frames(3);
    chk("k6_down_rel", 32'(kbus.key_down), 32'd0);

    base = nvalid;
    tap(4'h1); tap(4'h2); tap(4'h3); tap(4'hA); tap(4'h4);
    tap(4'h5); tap(4'h6); tap(4'hB); tap(4'h7);
    chk("seq_pulses", 32'(nvalid - base), 32'd9);
    chk("seq_data", kbus.data, 32'h23A456B7);
    chk("seq_code", 32'(kbus.key_code), 32'h7);

    base = nvalid;
    press(4'h0);
    frames(1);
    pressed = '0;
    frames(1);
    press(4'hD);
    frames(5);
    pressed = '0;
    frames(4);
    chk("glitch_pulses", 32'(nvalid - base), 32'd1);
    chk("glitch_code", 32'(kbus.key_code), 32'hD);

    base = nvalid;
    press(4'h5);
    frames(5);
    press(4'h9);
    frames(3);
    chk("multi_pulses", 32'(nvalid - base), 32'd1);
    chk("multi_code", 32'(kbus.key_code), 32'h5);
    chk("multi_down", 32'(kbus.key_down), 32'd1);
    pressed[pos_of(4'h9)] = 1'b0;
    frames(3);
    chk("multi_back_pulses", 32'(nvalid - base), 32'd1);
    chk("multi_back_down", 32'(kbus.key_down), 32'd1);
    pressed = '0;
    frames(1);
    chk("multi_rel_hold", 32'(kbus.key_down), 32'd1);
    frames(3);
    chk("multi_rel_down", 32'(kbus.key_down), 32'd0);

    kbus.clear = 1'b1;
    @(negedge clk);
    kbus.clear = 1'b0;
    chk("clr_data", kbus.data, 32'd0);
    chk("clr_code_kept", 32'(kbus.key_code), 32'h5);
    tap(4'h1); tap(4'h2); tap(4'h3); tap(4'h4);
    tap(4'h5); tap(4'h6); tap(4'h7); tap(4'h8);
    chk("pre_clr_data", kbus.data, 32'h12345678);

    sync_frame();
    press(4'hE);
    repeat (31) @(negedge clk);
    kbus.clear = 1'b1;
    @(negedge clk);
    kbus.clear = 1'b0;
    chk("clracc_valid", 32'(kbus.key_valid), 32'd1);
    chk("clracc_data", kbus.data, 32'h0000000E);
    chk("clracc_code", 32'(kbus.key_code), 32'hE);
    @(negedge clk);
    chk("clracc_pulse_end", 32'(kbus.key_valid), 32'd0);
    chk("clracc_down", 32'(kbus.key_down), 32'd1);

    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_col", 32'(col), 32'h0000000E);
    chk("arst_down", 32'(kbus.key_down), 32'd0);
    chk("arst_code", 32'(kbus.key_code), 32'd0);
    chk("arst_data", kbus.data, 32'd0);
    chk("arst_valid", 32'(kbus.key_valid), 32'd0);
    pressed = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
